// File: rtl/adc_avg_pkg.sv
// Shared types and sizing helpers for the ADC moving-average filter.
package adc_avg_pkg;

    localparam int unsigned SAMPLE_W = 10;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // Accumulator width for a 2^log2_n window of SAMPLE_W-bit samples.
    function automatic int unsigned sum_width(input int unsigned log2_n);
        return SAMPLE_W + log2_n + 1;
    endfunction

endpackage

// File: rtl/adc_moving_avg_if.sv
// Sample stream into the filter and averaged stream out of it.
interface adc_moving_avg_if
    import adc_avg_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W
);
    logic             data_valid;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             full;

    modport master (
        output data_valid,
        output data_in,
        input  data_out,
        input  out_valid,
        input  full
    );

    modport slave (
        input  data_valid,
        input  data_in,
        output data_out,
        output out_valid,
        output full
    );
endinterface

// File: rtl/sample_ring.sv
// N-entry register ring holding the averaging window; clears in one cycle.
module sample_ring
    import adc_avg_pkg::*;
#(
    parameter int unsigned WIDTH  = SAMPLE_W,
    parameter int unsigned LOG2_N = 3
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic [WIDTH-1:0] oldest_c_o
);
    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned PTR_W = (LOG2_N > 0) ? LOG2_N : 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] ring_q [N];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(N - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                ring_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            if (wr_en_i) begin
                ring_q[wr_ptr_q] <= wr_data_i;
            end
        end
    end

    // The slot about to be overwritten is the oldest sample in the window.
    assign oldest_c_o = ring_q[wr_ptr_q];

endmodule

// File: rtl/adc_moving_avg.sv
// Boxcar moving average over the last 2^LOG2_N ADC samples.
// Define ADC_MOVING_AVG_ROUND_EN for round-half-up output instead of truncation.
module adc_moving_avg
    import adc_avg_pkg::*;
#(
    parameter int unsigned WIDTH  = SAMPLE_W,
    parameter int unsigned LOG2_N = 3
) (
    input logic              sysclk,
    input logic              reset,
    adc_moving_avg_if.slave  avg_if
);
    localparam int unsigned N      = 1 << LOG2_N;
    localparam int unsigned SUM_W  = sum_width(LOG2_N) - SAMPLE_W + WIDTH;
    localparam int unsigned FILL_W = LOG2_N + 1;

    logic             dv_prev_q;
    logic             acc_q;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             out_valid_q, out_valid_d;
    logic             accept_c;
    logic [WIDTH-1:0] oldest_c;
    logic [SUM_W-1:0] sum_adj_c;

    assign accept_c = avg_if.data_valid & ~dv_prev_q;

    sample_ring #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clk_i      (sysclk),
        .clr_i      (reset),
        .wr_en_i    (accept_c),
        .wr_data_i  (avg_if.data_in),
        .oldest_c_o (oldest_c)
    );

`ifdef ADC_MOVING_AVG_ROUND_EN
    // Adding N/2 before the shift gives round-half-up; N/2 is 0 for N=1.
    assign sum_adj_c = sum_q + SUM_W'(N >> 1);
`else
    assign sum_adj_c = sum_q;
`endif

    always_comb begin
        sum_d       = sum_q;
        fill_d      = fill_q;
        full_d      = full_q;
        out_valid_d = acc_q;
        data_out_d  = data_out_q;
        if (accept_c) begin
            // The evicted sample is already inside sum, so this never underflows.
            sum_d = sum_q + SUM_W'(avg_if.data_in) - SUM_W'(oldest_c);
            if (fill_q != FILL_W'(N)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            full_d = full_q | (fill_d == FILL_W'(N));
        end
        if (acc_q) begin
            data_out_d = WIDTH'(sum_adj_c >> LOG2_N);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            dv_prev_q   <= 1'b1;
            acc_q       <= 1'b0;
            sum_q       <= '0;
            fill_q      <= '0;
            full_q      <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            dv_prev_q   <= avg_if.data_valid;
            acc_q       <= accept_c;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            full_q      <= full_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign avg_if.data_out  = data_out_q;
    assign avg_if.out_valid = out_valid_q;
    assign avg_if.full      = full_q;

endmodule

// File: tb/tb_adc_moving_avg.sv
// Randomized and directed bench for adc_moving_avg against a windowed-average model.
module tb_adc_moving_avg;
    import adc_avg_pkg::*;

    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #10 clk = ~clk;

    adc_moving_avg_if #(.WIDTH(SAMPLE_W)) avg_if ();

    adc_moving_avg #(
        .WIDTH  (SAMPLE_W),
        .LOG2_N (LOG2_N)
    ) dut (
        .sysclk (clk),
        .reset  (rst),
        .avg_if (avg_if)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ov_cnt = 0;
    int   exp_total = 0;
    int   n_acc = 0;
    int   win[$];
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected output: mean of the last N accepted samples, missing ones count as 0.
    function automatic int model_avg();
        int s = 0;
        foreach (win[i]) s += win[i];
`ifdef ADC_MOVING_AVG_ROUND_EN
        return (s + N / 2) / N;
`else
        return s / N;
`endif
    endfunction

    task automatic model_accept(input int v, input int due);
        exp_t e;
        win.push_back(v);
        if (win.size() > N) void'(win.pop_front());
        n_acc++;
        e.val = model_avg();
        e.due = due;
        exp_q.push_back(e);
        exp_total++;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (avg_if.out_valid === 1'b1) begin
            ov_cnt++;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_eq("data_out", 32'(avg_if.data_out), mon_e.val);
                check_eq("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic send(input int v, input int hold, input int gap);
        @(negedge clk);
        avg_if.data_in    = SAMPLE_W'(v);
        avg_if.data_valid = 1'b1;
        model_accept(v, cyc + 2);
        repeat (hold) @(negedge clk);
        avg_if.data_valid = 1'b0;
        if (gap > 1) repeat (gap - 1) @(negedge clk);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (exp_q.size() > 0) begin
            check_eq("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic check_full();
        check_eq("full", 32'(avg_if.full), 32'(n_acc >= N));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_data_out"}, 32'(avg_if.data_out), 0);
        check_eq({tag, "_out_valid"}, 32'(avg_if.out_valid), 0);
        check_eq({tag, "_full"}, 32'(avg_if.full), 0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        avg_if.data_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        win.delete();
        exp_q.delete();
        n_acc = 0;
        #1;
        check_reset_state("rst");
    endtask

    initial begin
        int ov_start;
        avg_if.data_valid = 1'b0;
        avg_if.data_in    = '0;

        reset_dut();

        // Constant ramp-up then window slide with 7->0 pointer wrap.
        for (int i = 0; i < N; i++) begin
            send(800, 1, 1);
            drain();
            check_full();
        end
        for (int i = 0; i < N; i++) begin
            send(0, 1, 1);
            drain();
            check_full();
        end

        // A held level counts as a single sample.
        reset_dut();
        ov_start = ov_cnt;
        send(512, 20, 1);
        drain();
        repeat (5) @(negedge clk);
        check_eq("level_pulses", ov_cnt - ov_start, 1);

        // Reset coincident with an accept discards that sample.
        reset_dut();
        for (int i = 0; i < 5; i++) send(1023, 1, 1);
        drain();
        repeat (2) @(negedge clk);
        ov_start = ov_cnt;
        rst = 1'b1;
        avg_if.data_valid = 1'b1;
        avg_if.data_in    = SAMPLE_W'(1023);
        @(negedge clk);
        rst = 1'b0;
        avg_if.data_valid = 1'b0;
        win.delete();
        n_acc = 0;
        #1;
        check_reset_state("midrst");
        repeat (4) @(negedge clk);
        check_eq("midrst_no_ov", ov_cnt - ov_start, 0);
        send(80, 1, 1);
        drain();

        // Rounding boundary and full-scale window.
        reset_dut();
        send(4, 1, 1);
        for (int i = 0; i < N - 1; i++) send(0, 1, 1);
        drain();
        for (int i = 0; i < N; i++) send(1023, 1, 1);
        drain();
        check_full();

        // Maximum accept rate: one sample every other cycle.
        reset_dut();
        ov_start = ov_cnt;
        for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 0 : 1023, 1, 1);
        drain();
        check_eq("maxrate_pulses", ov_cnt - ov_start, 16);

        // Randomized sample values and strobe shapes.
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(1023, 0)), int'($urandom_range(4, 1)), int'($urandom_range(3, 1)));
            if ($urandom_range(7, 0) == 0) begin
                drain();
                check_full();
            end
        end
        drain();
        check_full();

        repeat (4) @(negedge clk);
        check_eq("ov_total", ov_cnt, exp_total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_moving_avg.md
Name: adc_moving_avg

Overview:
- Boxcar moving-average filter on the ADC sample stream.
- Sits between spi2adc and echo. It consumes data_from_adc/data_valid, and echo receives its data_out/out_valid in place of the raw ADC signals.
- Averages the last 2^LOG2_N samples to suppress ADC noise before the echo and DAC/PWM path.
- One sample per 10 kHz tick; runs on the 50 MHz sysclk.

Parameters:
- WIDTH, 10: sample width in bits (unsigned ADC code).
- LOG2_N, 3: log2 of the window length N. Legal range 0..6. LOG2_N=0 is a registered passthrough.

Ports:
- sysclk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- data_valid  in  1  sample strobe from spi2adc; pulse or level, edge-detected
- data_in  in  WIDTH  unsigned sample from spi2adc
- data_out  out  WIDTH  averaged sample to echo
- out_valid  out  1  one-cycle strobe; data_out is new this cycle
- full  out  1  high once N samples have been accepted since reset

Behaviour:
- Clocking and reset:
  - Single clock domain, sysclk.
  - Reset is synchronous and active-high.
  - Reset values: data_out=0, out_valid=0, full=0, sum=0, wr_ptr=0, fill count=0, all N buffer entries=0, dv_prev=1.
  - dv_prev=1 ensures a data_valid level already high at reset release is not counted as a sample.
- Sample acceptance:
  - accept = data_valid & ~dv_prev.
  - dv_prev <= data_valid every cycle.
  - A level held high is one sample. Two separate single-cycle pulses need at least one low cycle between them.
- Accept edge (E0), all updates in the same edge:
  - sum <= sum + data_in - buf[wr_ptr].
  - buf[wr_ptr] <= data_in.
  - wr_ptr <= wr_ptr+1, wrapping modulo N (N-1 -> 0).
  - fill count increments, saturating at N.
- Output edge (E1):
  - data_out <= sum >> LOG2_N.
  - out_valid <= 1 for exactly one cycle.
  - Latency from the accept edge to out_valid high is 2 edges.
  - Back-to-back accepts (every other cycle) yield back-to-back averages; no stalls and no drops.
- full:
  - Registered; asserts on the edge where fill count reaches N.
  - Stays high until reset.
- Warm-up:
  - Before full, empty slots contribute 0, so the output ramps up: data_out = (sum of k samples)/N.
  - No special-casing of the warm-up period.
- Width and arithmetic:
  - sum is WIDTH+LOG2_N+1 bits and unsigned.
  - sum never exceeds N*(2^WIDTH-1), so it cannot overflow.
  - Subtraction is never negative because buf[wr_ptr] is already contained in sum.
- Reset mid-operation:
  - A reset coincident with accept wins; the sample is discarded.
  - A pending out_valid is cancelled.
  - The buffer is cleared in one cycle, so registers are used, not RAM.
- LOG2_N=0: the buffer is a single register. data_out = data_in of the last accepted sample, still at 2-edge latency.

Optional Feature:
- Macro: ADC_MOVING_AVG_ROUND_EN.
- Defined:
  - data_out <= (sum + 2^(LOG2_N-1)) >> LOG2_N, i.e. round-half-up.
  - The result is at most 2^WIDTH-1, so no saturation is needed.
  - When LOG2_N=0 the rounding term is 0.
- Undefined: truncation, data_out <= sum >> LOG2_N.
- Latency is identical either way.

Decomposition:
- Package adc_avg_pkg:
  - SAMPLE_W=10.
  - typedef sample_t (logic [SAMPLE_W-1:0]).
  - function sum_width(log2_n) returning SAMPLE_W+log2_n+1.
- One sub-module, sample_ring:
  - N-entry register circular buffer with wr_ptr and synchronous clear.
  - Provides the combinational read of the oldest entry plus a write-and-advance on accept.
  - The top module holds the edge detect, accumulator, fill counter and output register.

Test Plan (LOG2_N=3, N=8, ROUND_EN undefined unless stated):
- Constant input after reset: 8 pulses of data_in=800 -> data_out = 100,200,...,800. full rises with the 8th output; out_valid appears 2 edges after each accept.
- Window slide: 8 samples of 800, then 8 samples of 0 -> data_out = 700,600,...,0. Confirms the oldest sample is evicted and wr_ptr wraps 7->0.
- Level strobe: data_valid held high for 20 cycles with data_in=512 -> exactly one accept and one out_valid, data_out=64.
- Reset mid-stream: 5 samples of 1023, then reset asserted on the same cycle as a 6th accept -> no out_valid; data_out=0, full=0. The next sample of 80 gives data_out=10.
- Rounding: samples 4,0,0,0,0,0,0,0 -> first data_out=1 with ADC_MOVING_AVG_ROUND_EN defined, 0 without. 8x1023 -> 1023 in both builds.
- Max rate: accepts every 2nd cycle, alternating data_in 0/1023 for 16 samples -> 16 out_valid pulses, none dropped. Steady state alternates 511 (sum 4092) from truncation.
